// File: rtl/kh_cache_pkg.sv
// Shared definitions for the KH32 cache fill controllers (data and instruction side).
package kh_cache_pkg;

   localparam int unsigned CACHE_WORDS_DEF = 256;

   // Backing-memory direction encodings on mem_we.
   localparam logic MEM_RD = 1'b0;
   localparam logic MEM_WR = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      WB_RD,
      WB_WAIT,
      WB_WR,
      FILL_RD,
      FILL_WR,
      DONE,
      HOLD
   } fill_state_t;

endpackage

// File: rtl/kh_dcache_fill_ctrl.sv
// KH32 data-cache fill controller: optional write-back of the old window, then
// fill of [NEED_Base_Addr, NEED_High_Addr) clamped to CACHE_WORDS.
// Build option: KH_DCACHE_WB_EN enables the write-back path and old-window registers.
module kh_dcache_fill_ctrl
   import kh_cache_pkg::*;
#(
   parameter int unsigned CACHE_WORDS = CACHE_WORDS_DEF,
   parameter int unsigned AW          = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          NEED_change_cache,
   input  logic          NEED_WB_cache,
   input  logic [AW-1:0] NEED_Base_Addr,
   input  logic [AW-1:0] NEED_High_Addr,
   output logic [AW-1:0] NEED_Addr,
   output logic [31:0]   NEED_Din,
   input  logic [31:0]   NEED_Dout,
   output logic          NEED_WE,
   output logic          NEED_Done,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata,
   input  logic          mem_ack
);

   localparam int unsigned LW = $clog2(CACHE_WORDS) + 1;

   fill_state_t   state, state_n;
   logic [LW-1:0] idx, idx_n, idx_inc;
   logic [LW-1:0] len, len_n, len_req;
   logic [AW-1:0] new_base, new_base_n;
   logic [AW-1:0] span;
   logic [AW-1:0] addr_n, maddr_n;
   logic [31:0]   din_n, wdata_n;
   logic          we_n, done_n, req_n;
   logic          wb_go;
   logic          acked;

   assign idx_inc = idx + LW'(1);
   // An ack only counts while a request is actually outstanding.
   assign acked   = mem_req && mem_ack;

   // Requested window length, zero for an empty/inverted window, clamped to the cache depth.
   always_comb begin
      span = NEED_High_Addr - NEED_Base_Addr;
      if (NEED_High_Addr <= NEED_Base_Addr) begin
         len_req = '0;
      end else if (span >= AW'(CACHE_WORDS)) begin
         len_req = LW'(CACHE_WORDS);
      end else begin
         len_req = LW'(span);
      end
   end

`ifdef KH_DCACHE_WB_EN
   logic [AW-1:0] old_base;
   logic [LW-1:0] old_len;
   logic          old_valid;
   logic          mwe_n;

   assign wb_go = NEED_WB_cache && old_valid && (old_len != '0);

   // Remember the window just installed so the next request can write it back.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         old_base  <= '0;
         old_len   <= '0;
         old_valid <= 1'b0;
      end else if (state == DONE) begin
         old_base  <= new_base;
         old_len   <= len;
         old_valid <= 1'b1;
      end
   end
`else
   logic unused_wb;
   assign unused_wb = ^{NEED_WB_cache, NEED_Dout};
   assign wb_go     = 1'b0;
   assign mem_we    = MEM_RD;
`endif

   // Next-state and next-output logic; outputs are registered from these values so
   // every output reflects the state being entered.
   always_comb begin
      state_n    = state;
      idx_n      = idx;
      len_n      = len;
      new_base_n = new_base;
      addr_n     = NEED_Addr;
      din_n      = NEED_Din;
      maddr_n    = mem_addr;
      wdata_n    = mem_wdata;
      we_n       = 1'b0;
      done_n     = 1'b0;
      req_n      = 1'b0;
`ifdef KH_DCACHE_WB_EN
      mwe_n      = MEM_RD;
`endif
      unique case (state)
         IDLE: begin
            if (NEED_change_cache) begin
               new_base_n = NEED_Base_Addr;
               len_n      = len_req;
               idx_n      = '0;
               if (wb_go) begin
                  state_n = WB_RD;
                  addr_n  = '0;
               end else begin
                  state_n = FILL_RD;
                  req_n   = (len_req != '0);
                  maddr_n = NEED_Base_Addr;
               end
            end
         end
`ifdef KH_DCACHE_WB_EN
         WB_RD: begin
            state_n = WB_WAIT;
         end
         WB_WAIT: begin
            state_n = WB_WR;
            req_n   = 1'b1;
            mwe_n   = MEM_WR;
            maddr_n = old_base + AW'(idx);
            wdata_n = NEED_Dout;
         end
         WB_WR: begin
            if (acked) begin
               if (idx_inc == old_len) begin
                  idx_n   = '0;
                  state_n = FILL_RD;
                  req_n   = (len != '0);
                  maddr_n = new_base;
               end else begin
                  idx_n   = idx_inc;
                  state_n = WB_RD;
                  addr_n  = AW'(idx_inc);
               end
            end else begin
               req_n = 1'b1;
               mwe_n = MEM_WR;
            end
         end
`endif
         FILL_RD: begin
            if (len == '0) begin
               state_n = DONE;
               done_n  = 1'b1;
            end else if (acked) begin
               state_n = FILL_WR;
               we_n    = 1'b1;
               addr_n  = AW'(idx);
               din_n   = mem_rdata;
            end else begin
               req_n = 1'b1;
            end
         end
         FILL_WR: begin
            if (idx_inc == len) begin
               state_n = DONE;
               done_n  = 1'b1;
            end else begin
               idx_n   = idx_inc;
               state_n = FILL_RD;
               req_n   = 1'b1;
               maddr_n = new_base + AW'(idx_inc);
            end
         end
         DONE: begin
            state_n = HOLD;
         end
         HOLD: begin
            if (!NEED_change_cache) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State, counter, latched window and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         idx       <= '0;
         len       <= '0;
         new_base  <= '0;
         NEED_Addr <= '0;
         NEED_Din  <= '0;
         NEED_WE   <= 1'b0;
         NEED_Done <= 1'b0;
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
`ifdef KH_DCACHE_WB_EN
         mem_we    <= MEM_RD;
`endif
      end else begin
         state     <= state_n;
         idx       <= idx_n;
         len       <= len_n;
         new_base  <= new_base_n;
         NEED_Addr <= addr_n;
         NEED_Din  <= din_n;
         NEED_WE   <= we_n;
         NEED_Done <= done_n;
         mem_req   <= req_n;
         mem_addr  <= maddr_n;
         mem_wdata <= wdata_n;
`ifdef KH_DCACHE_WB_EN
         mem_we    <= mwe_n;
`endif
      end
   end

endmodule

// File: doc/kh_dcache_fill_ctrl.md
# kh_dcache_fill_ctrl

Memory-controller side of the KH32 data-cache `NEED_*` port; it services the core's cache-change requests. On a request it can first write the current cache window back to backing memory. It then fills the cache with the new window `[NEED_Base_Addr, NEED_High_Addr)` from backing memory and signals completion on `NEED_Done`. It sits between the core's MEM stage and the external word-addressed backing memory.

## Interface
Parameters:
- CACHE_WORDS, 256 — cache depth in 32-bit words; power of two.
- AW, 32 — address width.

Ports:
- clk  in  1  — single clock, rising edge.
- rst  in  1  — asynchronous, active-low reset.
- NEED_change_cache  in  1  — level request from core; held until Done is seen.
- NEED_WB_cache  in  1  — write back the old window first; sampled with the request.
- NEED_Base_Addr  in  32  — new window base (word address).
- NEED_High_Addr  in  32  — new window end, exclusive.
- NEED_Addr  out  32  — cache word offset (0..CACHE_WORDS-1).
- NEED_Din  out  32  — fill data into cache.
- NEED_Dout  in  32  — cache read data; valid 1 cycle after NEED_Addr.
- NEED_WE  out  1  — cache write strobe.
- NEED_Done  out  1  — one-cycle completion pulse.
- mem_req  out  1  — backing-memory request; held until mem_ack.
- mem_we  out  1  — 1 = write, 0 = read.
- mem_addr  out  32  — backing word address.
- mem_wdata  out  32  — write data.
- mem_rdata  in  32  — read data, valid with mem_ack.
- mem_ack  in  1  — one-cycle acknowledge; ends the request.

## Operation
- States: IDLE, WB_RD, WB_WAIT, WB_WR, FILL_RD, FILL_WR, DONE, HOLD.
- IDLE: on NEED_change_cache=1, latch new_base and len = min(High−Base, CACHE_WORDS).
  - If High ≤ Base, len = 0.
  - If NEED_WB_cache=1 and a valid old window exists, go to WB_RD; otherwise go to FILL_RD.
  - The offset counter idx is cleared on entry.
- WB_RD: drive NEED_Addr=idx, then go to WB_WAIT.
- WB_WAIT: capture NEED_Dout, then go to WB_WR.
- WB_WR: mem_req=1, mem_we=1, mem_addr=old_base+idx, wait for mem_ack.
  - If idx+1 == old_len, clear idx and go to FILL_RD.
  - Otherwise idx++ and go to WB_RD.
- FILL_RD: mem_req=1, mem_we=0, mem_addr=new_base+idx, wait for mem_ack.
  - On ack, register mem_rdata and go to FILL_WR.
- FILL_WR: NEED_WE=1 for one cycle with NEED_Addr=idx and NEED_Din=captured data.
  - If idx+1 == len, go to DONE; otherwise idx++ and go to FILL_RD.
- DONE: NEED_Done=1 for one cycle.
  - old_base := new_base, old_len := len, old_valid := 1.
  - Go to HOLD.
- HOLD: wait for NEED_change_cache=0, then go to IDLE. This prevents re-triggering on the held request level.
- len = 0: skip the fill and go straight to DONE after any write-back.
- old_len = 0, or old_valid = 0: the write-back phase is skipped.
- Address arithmetic is modulo 2^32; mem_addr wrap past 0xFFFFFFFF is allowed, not flagged.
- Base/High changes while busy are ignored; the values latched in IDLE are used.
- Request drop mid-operation: the sequence still completes, Done pulses, and the block goes to IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, idx 0, old_valid 0, old_base 0, old_len 0.
- Request to first mem_req: 1 cycle (fill only) or 3 cycles (with write-back).
- Per word, with ack latency A ≥ 1:
  - fill = A+1 cycles;
  - write-back = A+2 cycles.
- Done follows the last NEED_WE by 1 cycle. Earliest new request acceptance is 2 cycles after Done.
- mem_req, mem_addr, mem_we and mem_wdata are registered and stable while mem_req=1 and mem_ack=0.
- mem_ack in the same cycle as mem_req's first assertion is legal.
- mem_ack while mem_req=0 is ignored.
- NEED_WE and mem_req are never asserted in the same cycle.

## Configuration
- KH_DCACHE_WB_EN defined: write-back path present (WB_* states, old-window registers).
- Undefined:
  - NEED_WB_cache is ignored;
  - the WB states and the old_* registers are not built;
  - mem_we is tied to 0;
  - every request performs a fill only.

## Structure
- Shared package kh_cache_pkg holds:
  - the state enum fill_state_t;
  - CACHE_WORDS default;
  - MEM_RD/MEM_WR encodings, reused by the instruction-side controller.
- No sub-module is warranted: it is a single FSM plus an idx counter, with an estimated 200–300 lines of RTL.

## Test plan
- Fill only: Base=0x100, High=0x104, WB=0, mem_ack latency 1, mem_rdata=addr^0xA5A5A5A5 → four NEED_WE writes at offsets 0..3 with data 0xA5A5A4A5..0xA5A5A4A6; Done one cycle after the last write.
- Write-back then fill: prior window 0x100..0x104, cache holds 0x11..0x14, request Base=0x200, High=0x202, WB=1 → mem writes 0x100..0x103 with 0x11..0x14, then reads 0x200 and 0x201, two NEED_WE writes, Done.
- Clamp: Base=0, High=0x1000, CACHE_WORDS=256 → exactly 256 fills, last at NEED_Addr=0xFF.
- Empty window: Base=0x50, High=0x50 → no mem_req; Done 2 cycles after the request.
- Held request: NEED_change_cache held 20 cycles after Done → no second sequence; drop then raise → new sequence.
- Async reset asserted in FILL_RD with mem_req=1 → all outputs 0 immediately; old_valid=0; the next request with WB=1 does no write-back.
